// File: rtl/ahbl_pkg.sv
// Shared AHB-Lite encodings and helpers for the parametrised splitter
// (ahbl_splitter_n and its default slave).
package ahbl_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_e;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  // Default-slave state encoding
  typedef logic [1:0] def_state_t;
  localparam def_state_t DEF_IDLE = 2'd0;
  localparam def_state_t DEF_ERR1 = 2'd1;
  localparam def_state_t DEF_ERR2 = 2'd2;

  localparam int unsigned MAX_SLAVES = 16;
  localparam int unsigned IDS_W      = 4 * MAX_SLAVES;

  // Region ID of subordinate idx from a flattened ID vector (zero-extended to 16 slots)
  function automatic logic [3:0] region_id(input logic [IDS_W-1:0] ids,
                                           input int unsigned      idx);
    return ids[idx*4 +: 4];
  endfunction

endpackage

// File: rtl/ahbl_default_slave.sv
// Integrated default slave: two-cycle ERROR response for unmapped transfers.
// Optional wait-state timeout takeover is built when AHBL_SPLITTER_TIMEOUT_EN is defined.
module ahbl_default_slave
  import ahbl_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_hready,     // bus HREADY as seen by the manager
  input  logic i_err_req,    // NONSEQ/SEQ to an unmapped region in the address phase
  input  logic i_dp_def,     // current data phase belongs to an unmapped transfer
  input  logic i_dp_stall,   // a selected subordinate is inserting wait states
  output logic o_def_hready,
  output logic o_def_hresp,
  output logic o_decerr,
  output logic o_timeout,
  output logic o_takeover    // splitter seizes the stalled data phase
);

  def_state_t r_state;
  def_state_t w_state_nxt;
  logic       w_takeover;

`ifdef AHBL_SPLITTER_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] r_cnt;

  // Takeover on the stall cycle that brings the count to TIMEOUT_CYCLES
  assign w_takeover = i_dp_stall && (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_hready) begin
      r_cnt <= '0;
    end else if (i_dp_stall) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end
`else
  logic w_unused;

  assign w_takeover = 1'b0;
  assign w_unused   = i_dp_stall & (TIMEOUT_CYCLES != 0);
`endif

  assign o_takeover = w_takeover;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= DEF_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // NOTE: each always_comb assigns defaults first so no path can infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      DEF_IDLE: begin
        if ((i_hready && i_err_req) || w_takeover) begin
          w_state_nxt = DEF_ERR1;
        end
      end
      DEF_ERR1: w_state_nxt = DEF_ERR2;
      DEF_ERR2: w_state_nxt = (i_hready && i_err_req) ? DEF_ERR1 : DEF_IDLE;
      default:  w_state_nxt = DEF_IDLE;
    endcase
  end

  always_comb begin
    o_def_hready = 1'b1;
    o_def_hresp  = HRESP_OKAY;
    o_decerr     = 1'b0;
    o_timeout    = 1'b0;
    case (r_state)
      DEF_ERR1: begin
        o_def_hready = 1'b0;
        o_def_hresp  = HRESP_ERROR;
      end
      DEF_ERR2: begin
        o_def_hresp = HRESP_ERROR;
        // A timed-out data phase was mapped, so dp_def tells the two causes apart
        o_decerr    = i_dp_def;
`ifdef AHBL_SPLITTER_TIMEOUT_EN
        o_timeout   = ~i_dp_def;
`endif
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/ahbl_splitter_n.sv
// AHB-Lite one-to-NUM_SLAVES address decoder and response mux with integrated
// default slave; optional wait-state timeout via AHBL_SPLITTER_TIMEOUT_EN.
module ahbl_splitter_n
  import ahbl_pkg::*;
#(
  parameter int unsigned                 NUM_SLAVES     = 8,
  parameter logic [4*NUM_SLAVES-1:0]     SLAVE_IDS      = {4'h8, 4'h7, 4'h6, 4'h5,
                                                           4'h4, 4'h3, 4'h2, 4'h0},
  parameter int unsigned                 TIMEOUT_CYCLES = 255
) (
  input  logic                     HCLK,
  input  logic                     HRESETn,
  input  logic [31:0]              HADDR,
  input  logic [1:0]               HTRANS,
  output logic                     HREADY,
  output logic [31:0]              HRDATA,
  output logic                     HRESP,
  output logic [NUM_SLAVES-1:0]    S_HSEL,
  input  logic [32*NUM_SLAVES-1:0] S_HRDATA,
  input  logic [NUM_SLAVES-1:0]    S_HREADYOUT,
  input  logic [NUM_SLAVES-1:0]    S_HRESP,
  output logic                     DECERR,
  output logic                     TIMEOUT
);

  localparam logic [IDS_W-1:0] IDS_EXT = IDS_W'(SLAVE_IDS);

  logic [NUM_SLAVES-1:0] w_match;
  logic [NUM_SLAVES-1:0] w_sel;
  logic [NUM_SLAVES:0]   w_hit_below;
  logic                  w_unmapped;
  logic [31:0]           w_rdata_term [NUM_SLAVES];
  logic [31:0]           w_rdata_or;
  logic                  w_dp_mapped;
  logic                  w_dp_stall;
  logic                  w_def_hready;
  logic                  w_def_hresp;
  logic                  w_takeover;
  logic                  w_unused;

  logic [NUM_SLAVES-1:0] r_dp_sel;
  logic                  r_dp_def;

  // Priority chain: a match is selected only if no lower-index slave matches
  assign w_hit_below[0] = 1'b0;
  for (genvar gi = 0; gi < NUM_SLAVES; gi++) begin : g_decode
    assign w_match[gi]       = (HADDR[31:28] == region_id(IDS_EXT, gi));
    assign w_sel[gi]         = w_match[gi] & ~w_hit_below[gi];
    assign w_hit_below[gi+1] = w_hit_below[gi] | w_match[gi];
  end

  assign w_unmapped = ~w_hit_below[NUM_SLAVES];
  assign S_HSEL     = w_sel;
  assign w_unused   = ^{HADDR[27:0], HTRANS[0]};

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_dp_sel <= '0;
      r_dp_def <= 1'b0;
    end else if (HREADY) begin
      r_dp_sel <= w_sel;
      r_dp_def <= HTRANS[1] & w_unmapped;
    end else if (w_takeover) begin
      r_dp_sel <= '0;
    end
  end

  for (genvar gi = 0; gi < NUM_SLAVES; gi++) begin : g_rdata
    assign w_rdata_term[gi] = r_dp_sel[gi] ? S_HRDATA[32*gi +: 32] : 32'h0;
  end

  always_comb begin
    w_rdata_or = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      w_rdata_or = w_rdata_or | w_rdata_term[i];
    end
  end

  assign w_dp_mapped = |r_dp_sel;
  assign HREADY      = w_dp_mapped ? |(r_dp_sel & S_HREADYOUT) : w_def_hready;
  assign HRESP       = w_dp_mapped ? |(r_dp_sel & S_HRESP)     : w_def_hresp;
  assign HRDATA      = w_rdata_or;
  assign w_dp_stall  = w_dp_mapped & ~HREADY;

  ahbl_default_slave #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_default_slave (
    .i_clk        (HCLK),
    .i_rst_n      (HRESETn),
    .i_hready     (HREADY),
    .i_err_req    (HTRANS[1] & w_unmapped),
    .i_dp_def     (r_dp_def),
    .i_dp_stall   (w_dp_stall),
    .o_def_hready (w_def_hready),
    .o_def_hresp  (w_def_hresp),
    .o_decerr     (DECERR),
    .o_timeout    (TIMEOUT),
    .o_takeover   (w_takeover)
  );

  a_hsel_onehot: assert property (@(posedge HCLK) disable iff (!HRESETn) $onehot0(S_HSEL));
  a_dpsel_onehot: assert property (@(posedge HCLK) disable iff (!HRESETn) $onehot0(r_dp_sel));

endmodule

// File: tb/tb_ahbl_splitter_n.sv
// Self-checking bench for ahbl_splitter_n: decode table, directed and random
// transfer streams against a transfer-level model, timeout/long stall, async reset.
module tb_ahbl_splitter_n;
  import ahbl_pkg::*;

  localparam int NS     = 8;
  localparam int TO_CYC = 4;
  // Slave 7 duplicates slave 6's region so the lowest-index rule is exercised
  localparam logic [4*NS-1:0] IDS = {4'h7, 4'h7, 4'h6, 4'h5, 4'h4, 4'h3, 4'h2, 4'h0};

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [31:0]       haddr;
  logic [1:0]        htrans;
  logic              hready;
  logic [31:0]       hrdata;
  logic              hresp;
  logic [NS-1:0]     s_hsel;
  logic [32*NS-1:0]  s_hrdata;
  logic [NS-1:0]     s_hreadyout;
  logic [NS-1:0]     s_hresp;
  logic              decerr;
  logic              timeout;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  ahbl_splitter_n #(
    .NUM_SLAVES     (NS),
    .SLAVE_IDS      (IDS),
    .TIMEOUT_CYCLES (TO_CYC)
  ) dut (
    .HCLK        (clk),
    .HRESETn     (rst_n),
    .HADDR       (haddr),
    .HTRANS      (htrans),
    .HREADY      (hready),
    .HRDATA      (hrdata),
    .HRESP       (hresp),
    .S_HSEL      (s_hsel),
    .S_HRDATA    (s_hrdata),
    .S_HREADYOUT (s_hreadyout),
    .S_HRESP     (s_hresp),
    .DECERR      (decerr),
    .TIMEOUT     (timeout)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- subordinate environment ----------------
  int          cfg_ws    [NS];
  bit          cfg_err   [NS];
  bit          cfg_stall [NS];
  logic [31:0] salt      [NS];
  bit          s_act     [NS];
  int          s_pos     [NS];
  logic [31:0] s_addr    [NS];

  task automatic cfg_default();
    for (int i = 0; i < NS; i++) begin
      cfg_ws[i] = 0; cfg_err[i] = 1'b0; cfg_stall[i] = 1'b0; s_act[i] = 1'b0;
      salt[i] = 32'h1357_9BDF * (i + 3);
    end
    salt[1] = 32'hFEAD_BEFF;  // 0x2000_0010 reads back as 0xDEADBEEF
  endtask

  task automatic drive_slaves();
    for (int i = 0; i < NS; i++) begin
      logic        rdy, rsp;
      logic [31:0] d;
      rdy = 1'b1; rsp = 1'b0; d = 32'h0;
      if (s_act[i]) begin
        if (cfg_stall[i] || s_pos[i] < cfg_ws[i]) rdy = 1'b0;
        else if (cfg_err[i] && s_pos[i] == cfg_ws[i]) begin rdy = 1'b0; rsp = 1'b1; end
        else begin rsp = cfg_err[i]; d = cfg_err[i] ? 32'h0 : (s_addr[i] ^ salt[i]); end
      end
      s_hreadyout[i]       = rdy;
      s_hresp[i]           = rsp;
      s_hrdata[32*i +: 32] = d;
    end
  endtask

  task automatic advance_slaves(input logic rdy, input logic [NS-1:0] sel,
                                input logic [1:0] tr, input logic [31:0] a);
    for (int i = 0; i < NS; i++) begin
      if (rdy && sel[i] && tr[1]) begin
        s_act[i] = 1'b1; s_pos[i] = 0; s_addr[i] = a;
      end else if (s_act[i] && !cfg_stall[i]) begin
        if (s_pos[i] == cfg_ws[i] + (cfg_err[i] ? 1 : 0)) s_act[i] = 1'b0;
        else s_pos[i]++;
      end
    end
  endtask

  // ---------------- transfer-level reference model ----------------
  typedef struct packed {
    logic        rdy;
    logic        rsp;
    logic [31:0] data;
    logic        dec;
    logic        to;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] tr_addr[$];
  logic [1:0]  tr_trans[$];

  function automatic int ref_slave(input logic [31:0] a);
    logic [4*NS-1:0] ids;
    ids = IDS;
    for (int i = 0; i < NS; i++) if (a[31:28] == ids[4*i +: 4]) return i;
    return -1;
  endfunction

  function automatic logic [NS-1:0] ref_sel(input logic [31:0] a);
    logic [NS-1:0] v;
    int s;
    v = '0;
    s = ref_slave(a);
    if (s >= 0) v[s] = 1'b1;
    return v;
  endfunction

  function automatic exp_t mk(input logic rdy, input logic rsp, input logic [31:0] d,
                              input logic dec, input logic to);
    exp_t e;
    e.rdy = rdy; e.rsp = rsp; e.data = d; e.dec = dec; e.to = to;
    return e;
  endfunction

  // Append the data-phase cycles one transfer should produce
  function automatic void push_exp(input logic [31:0] a, input logic [1:0] t);
    int s;
    s = ref_slave(a);
    if (!t[1]) begin
      exp_q.push_back(mk(1'b1, 1'b0, 32'h0, 1'b0, 1'b0));
    end else if (s < 0) begin
      exp_q.push_back(mk(1'b0, 1'b1, 32'h0, 1'b0, 1'b0));
      exp_q.push_back(mk(1'b1, 1'b1, 32'h0, 1'b1, 1'b0));
    end else if (cfg_stall[s]) begin
      for (int c = 0; c < TO_CYC; c++) exp_q.push_back(mk(1'b0, 1'b0, 32'h0, 1'b0, 1'b0));
      exp_q.push_back(mk(1'b0, 1'b1, 32'h0, 1'b0, 1'b0));
      exp_q.push_back(mk(1'b1, 1'b1, 32'h0, 1'b0, 1'b1));
    end else begin
      for (int c = 0; c < cfg_ws[s]; c++) exp_q.push_back(mk(1'b0, 1'b0, 32'h0, 1'b0, 1'b0));
      if (cfg_err[s]) begin
        exp_q.push_back(mk(1'b0, 1'b1, 32'h0, 1'b0, 1'b0));
        exp_q.push_back(mk(1'b1, 1'b1, 32'h0, 1'b0, 1'b0));
      end else begin
        exp_q.push_back(mk(1'b1, 1'b0, a ^ salt[s], 1'b0, 1'b0));
      end
    end
  endfunction

  task automatic present(input int k);
    if (k < tr_addr.size()) begin haddr = tr_addr[k]; htrans = tr_trans[k]; end
    else begin haddr = 32'h0; htrans = HTRANS_IDLE; end
  endtask

  // Runs tr_addr/tr_trans as a pipelined manager; call at posedge+1
  task automatic run_stream();
    int            k;
    exp_t          e;
    logic          samp_rdy;
    logic [NS-1:0] samp_sel;
    k = 0;
    for (int i = 0; i < NS; i++) s_act[i] = 1'b0;
    exp_q.delete();
    exp_q.push_back(mk(1'b1, 1'b0, 32'h0, 1'b0, 1'b0));
    for (int i = 0; i < tr_addr.size(); i++) push_exp(tr_addr[i], tr_trans[i]);
    present(k);
    drive_slaves();
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      @(negedge clk);
      check("hsel",    64'(s_hsel),  64'(ref_sel(haddr)));
      check("hready",  64'(hready),  64'(e.rdy));
      check("hresp",   64'(hresp),   64'(e.rsp));
      check("hrdata",  64'(hrdata),  64'(e.data));
      check("decerr",  64'(decerr),  64'(e.dec));
      check("timeout", 64'(timeout), 64'(e.to));
      samp_rdy = hready;
      samp_sel = s_hsel;
      @(posedge clk);
      #1;
      advance_slaves(samp_rdy, samp_sel, htrans, haddr);
      if (samp_rdy && k < tr_addr.size()) k++;
      present(k);
      drive_slaves();
    end
  endtask

  task automatic add_tr(input logic [31:0] a, input logic [1:0] t);
    tr_addr.push_back(a);
    tr_trans.push_back(t);
  endtask

  // ---------------- decode table ----------------
  typedef struct {
    logic [31:0]   addr;
    logic [1:0]    trans;
    logic [NS-1:0] sel;
  } vec_t;

  vec_t vecs[11];

  initial begin
    vecs[0]  = '{32'h2000_0010, HTRANS_IDLE, 8'h02};
    vecs[1]  = '{32'h0000_0004, HTRANS_BUSY, 8'h01};
    vecs[2]  = '{32'h3123_4567, HTRANS_IDLE, 8'h04};
    vecs[3]  = '{32'h4000_0000, HTRANS_IDLE, 8'h08};
    vecs[4]  = '{32'h5000_0000, HTRANS_BUSY, 8'h10};
    vecs[5]  = '{32'h6FFF_FFFC, HTRANS_IDLE, 8'h20};
    vecs[6]  = '{32'h7000_0000, HTRANS_IDLE, 8'h40};
    vecs[7]  = '{32'h8000_0000, HTRANS_IDLE, 8'h00};
    vecs[8]  = '{32'hF000_0000, HTRANS_IDLE, 8'h00};
    vecs[9]  = '{32'hF000_0000, HTRANS_BUSY, 8'h00};
    vecs[10] = '{32'h1000_0000, HTRANS_IDLE, 8'h00};

    cfg_default();
    haddr  = 32'h0;
    htrans = HTRANS_IDLE;
    drive_slaves();

    // Reset values
    #1;
    check("rst_hready",  64'(hready),  64'd1);
    check("rst_hresp",   64'(hresp),   64'd0);
    check("rst_hrdata",  64'(hrdata),  64'd0);
    check("rst_decerr",  64'(decerr),  64'd0);
    check("rst_timeout", 64'(timeout), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Decode table: IDLE/BUSY only, so every data phase is a zero-wait OKAY
    for (int v = 0; v < 11; v++) begin
      haddr  = vecs[v].addr;
      htrans = vecs[v].trans;
      @(negedge clk);
      check("tbl_hsel",   64'(s_hsel), 64'(vecs[v].sel));
      check("tbl_hready", 64'(hready), 64'd1);
      check("tbl_hresp",  64'(hresp),  64'd0);
      check("tbl_decerr", 64'(decerr), 64'd0);
      @(posedge clk);
      #1;
    end
    haddr  = 32'h0;
    htrans = HTRANS_IDLE;

    // Directed stream
    cfg_default();
    cfg_ws[1] = 2;
    cfg_ws[5] = 1; cfg_err[5] = 1'b1;
    tr_addr.delete(); tr_trans.delete();
    add_tr(32'h2000_0010, HTRANS_NONSEQ);
    add_tr(32'hF000_0000, HTRANS_NONSEQ);
    add_tr(32'hF000_0000, HTRANS_IDLE);
    add_tr(32'h4000_0000, HTRANS_NONSEQ);
    add_tr(32'hB000_0000, HTRANS_NONSEQ);
    add_tr(32'h0000_0004, HTRANS_NONSEQ);
    add_tr(32'h9000_0000, HTRANS_NONSEQ);
    add_tr(32'hC000_0000, HTRANS_SEQ);
    add_tr(32'h6000_0100, HTRANS_NONSEQ);
    add_tr(32'h7000_0008, HTRANS_SEQ);
    add_tr(32'hE000_0000, HTRANS_BUSY);
    add_tr(32'h3000_0020, HTRANS_SEQ);
    run_stream();

    // Randomized stream
    cfg_default();
    for (int i = 0; i < NS; i++) begin
      cfg_ws[i]  = $urandom_range(0, 3);
      cfg_err[i] = ($urandom_range(0, 3) == 0);
    end
    tr_addr.delete(); tr_trans.delete();
    for (int n = 0; n < 250; n++) add_tr($urandom(), 2'($urandom_range(0, 3)));
    run_stream();

    // Stalled subordinate 3 followed by a ROM read
    cfg_default();
`ifdef AHBL_SPLITTER_TIMEOUT_EN
    cfg_stall[3] = 1'b1;
`else
    cfg_ws[3] = 20;
`endif
    tr_addr.delete(); tr_trans.delete();
    add_tr(32'h4000_0000, HTRANS_NONSEQ);
    add_tr(32'h0000_0004, HTRANS_NONSEQ);
    run_stream();

    // Asynchronous reset while the default slave is in ERR1
    cfg_default();
    drive_slaves();
    haddr  = 32'hF000_0000;
    htrans = HTRANS_NONSEQ;
    @(negedge clk);
    check("pre_err_hready", 64'(hready), 64'd1);
    @(posedge clk);
    #1;
    haddr  = 32'h0;
    htrans = HTRANS_IDLE;
    #1;
    check("err1_hready", 64'(hready), 64'd0);
    check("err1_hresp",  64'(hresp),  64'd1);
    rst_n = 1'b0;
    #1;
    check("arst_hready", 64'(hready), 64'd1);
    check("arst_hresp",  64'(hresp),  64'd0);
    check("arst_hrdata", 64'(hrdata), 64'd0);
    check("arst_decerr", 64'(decerr), 64'd0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    cfg_ws[1] = 2;
    tr_addr.delete(); tr_trans.delete();
    add_tr(32'h2000_0010, HTRANS_NONSEQ);
    run_stream();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
